// File: rtl/reg_file_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | reg_file_pkg                                                             |
// | Shared types and helpers for the multi-port register file: the clear    |
// | engine state encoding and the address legality check that the hazard    |
// | unit also uses.                                                          |
// | Revision: 1.0 - initial multi-port release                               |
// +--------------------------------------------------------------------------+
package reg_file_pkg;

    // CLEAR: the array is being swept to zero, reads return 0.
    // RUN:   the array holds valid contents, reads and writes are live.
    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } rf_state_t;

    // An address is usable for a read or a write when it names an existing
    // entry and is not the hard-wired zero register.
    function automatic logic rf_addr_ok(input int unsigned addr,
                                        input int unsigned nregs,
                                        input logic        zero_reg);
        return (addr < nregs) && !(zero_reg && (addr == 0));
    endfunction

endpackage : reg_file_pkg
`default_nettype wire

// File: rtl/reg_file_clear_fsm.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | reg_file_clear_fsm                                                       |
// | Sequential clear engine: after reset or an accepted clear request it     |
// | zeroes one array entry per cycle, then declares the array ready.         |
// | Ports:                                                                   |
// |   clk       in   rising-edge clock                                       |
// |   reset     in   synchronous active-high reset, restarts the sweep       |
// |   clear_req in   start a new sweep, honoured only while ready            |
// |   ready     out  1 = array contents valid                                |
// |   clr_en    out  1 = zero mem[clr_addr] on this edge                     |
// |   clr_addr  out  entry being cleared                                     |
// | Revision: 1.0 - initial multi-port release                               |
// +--------------------------------------------------------------------------+
module reg_file_clear_fsm
    import reg_file_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int AW    = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear_req,
    output logic          ready,
    output logic          clr_en,
    output logic [AW-1:0] clr_addr
);

    localparam logic [AW-1:0] c_last_addr = AW'(NREGS - 1);

    rf_state_t     r_state;
    rf_state_t     w_state_nxt;
    logic [AW-1:0] r_ptr;
    logic [AW-1:0] w_ptr_nxt;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= CLEAR;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // Next-state logic. The pointer only matters in CLEAR; in RUN it is
    // parked and reloaded with 0 when a sweep is requested.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            CLEAR: begin
                w_ptr_nxt = r_ptr + AW'(1);
                if (r_ptr == c_last_addr) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (clear_req) begin
                    w_state_nxt = CLEAR;
                    w_ptr_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = CLEAR;
                w_ptr_nxt   = '0;
            end
        endcase
    end

    // Outputs
    always_comb begin
        ready    = (r_state == RUN);
        clr_en   = (r_state == CLEAR);
        clr_addr = r_ptr;
    end

endmodule : reg_file_clear_fsm
`default_nettype wire

// File: rtl/reg_file_mp.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | reg_file_mp                                                              |
// | Multi-port register file: NREGS x XLEN storage, NRD combinational read   |
// | ports, two write ports (port 1 wins on collision), optional hard-wired   |
// | zero register, optional same-cycle write-to-read bypass and a one-entry- |
// | per-cycle clear engine instead of a full-array reset.                    |
// | Ports:                                                                   |
// |   clk, reset            clock, synchronous active-high reset            |
// |   clear_req             start a clear sweep (only while ready)          |
// |   ready                 1 = array valid, 0 during a sweep               |
// |   we0/waddr0/wdata0     write port 0                                    |
// |   we1/waddr1/wdata1     write port 1                                    |
// |   raddr                 read addresses, port k at [k*AW +: AW]          |
// |   rdata                 read data, port k at [k*XLEN +: XLEN]           |
// | Revision: 1.0 - initial multi-port release                               |
// +--------------------------------------------------------------------------+
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter  int XLEN     = 32,
    parameter  int NREGS    = 32,
    parameter  int NRD      = 2,
    parameter  int ZERO_REG = 1,
    parameter  int BYPASS   = 1,
    localparam int AW       = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_req,
    output logic              ready,
    input  logic              we0,
    input  logic [AW-1:0]     waddr0,
    input  logic [XLEN-1:0]   wdata0,
    input  logic              we1,
    input  logic [AW-1:0]     waddr1,
    input  logic [XLEN-1:0]   wdata1,
    input  logic [NRD*AW-1:0] raddr,
    output logic [NRD*XLEN-1:0] rdata
);

    localparam logic c_zero_reg = (ZERO_REG != 0);

    logic [XLEN-1:0] r_mem [NREGS];

    logic            w_clr_en;
    logic [AW-1:0]   w_clr_addr;
    logic            w_wr_go;
    logic            w_wr0;
    logic            w_wr1;

    reg_file_clear_fsm #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_clear_fsm (
        .clk       (clk),
        .reset     (reset),
        .clear_req (clear_req),
        .ready     (ready),
        .clr_en    (w_clr_en),
        .clr_addr  (w_clr_addr)
    );

    // A clear request accepted in RUN drops the writes of the same cycle.
    assign w_wr_go = ready && !clear_req;
    assign w_wr0   = w_wr_go && we0 && rf_addr_ok(32'(waddr0), NREGS, c_zero_reg);
    assign w_wr1   = w_wr_go && we1 && rf_addr_ok(32'(waddr1), NREGS, c_zero_reg);

    // The reset edge leaves the array alone; the sweep that follows does the
    // zeroing. Port 1 is written last so it wins an address collision.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (w_clr_en) begin
                r_mem[w_clr_addr] <= '0;
            end else begin
                if (w_wr0) begin
                    r_mem[waddr0] <= wdata0;
                end
                if (w_wr1) begin
                    r_mem[waddr1] <= wdata1;
                end
            end
        end
    end

    // Read ports. Illegal addresses and a not-ready array read 0 regardless
    // of any matching write, so the bypass sits inside the legality check.
    // A matching write address is legal whenever the read address is.
    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   w_ra;
        logic [XLEN-1:0] w_rd;

        assign w_ra = raddr[k*AW +: AW];

        always_comb begin
            w_rd = '0;
            if (ready && rf_addr_ok(32'(w_ra), NREGS, c_zero_reg)) begin
                w_rd = r_mem[w_ra];
                if ((BYPASS != 0) && !clear_req) begin
                    if (we0 && (waddr0 == w_ra)) begin
                        w_rd = wdata0;
                    end
                    if (we1 && (waddr1 == w_ra)) begin
                        w_rd = wdata1;
                    end
                end
            end
        end

        assign rdata[k*XLEN +: XLEN] = w_rd;
    end

endmodule : reg_file_mp
`default_nettype wire

// File: tb/tb_reg_file_mp.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_reg_file_mp                                                           |
// | Scoreboard bench for reg_file_mp. Two instances share one stimulus:      |
// |   unit 0: NREGS=32, ZERO_REG=1, BYPASS=1                                 |
// |   unit 1: NREGS=24, ZERO_REG=1, BYPASS=0                                 |
// | The stimulus drives a cycle's inputs, queues the hand-computed outputs   |
// | expected during that cycle, then advances one edge; the monitor pops and |
// | compares on the falling edge.                                            |
// | Revision: 1.0 - initial multi-port release                               |
// +--------------------------------------------------------------------------+
module tb_reg_file_mp;

    logic        clk;
    logic        reset;
    logic        clear_req;
    logic        we0;
    logic [4:0]  waddr0;
    logic [31:0] wdata0;
    logic        we1;
    logic [4:0]  waddr1;
    logic [31:0] wdata1;
    logic [9:0]  raddr;
    logic        ready_a;
    logic        ready_b;
    logic [63:0] rdata_a;
    logic [63:0] rdata_b;

    reg_file_mp #(
        .XLEN(32), .NREGS(32), .NRD(2), .ZERO_REG(1), .BYPASS(1)
    ) dut_a (
        .clk(clk), .reset(reset), .clear_req(clear_req), .ready(ready_a),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr(raddr), .rdata(rdata_a)
    );

    reg_file_mp #(
        .XLEN(32), .NREGS(24), .NRD(2), .ZERO_REG(1), .BYPASS(0)
    ) dut_b (
        .clk(clk), .reset(reset), .clear_req(clear_req), .ready(ready_b),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr(raddr), .rdata(rdata_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          unit;   // 0 = dut_a, 1 = dut_b
        int          kind;   // 0 = rdata port, 1 = ready
        int          port;
        logic [31:0] exp;
    } chk_t;

    chk_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   done   = 1'b0;

    task automatic push(input string n, input int u, input int k, input int p,
                        input logic [31:0] v);
        chk_t c;
        c.name = n; c.unit = u; c.kind = k; c.port = p; c.exp = v;
        q.push_back(c);
    endtask

    task automatic rd(input string n, input int u, input int p, input logic [31:0] v);
        push(n, u, 0, p, v);
    endtask

    task automatic rdy(input string n, input int u, input logic v);
        push(n, u, 1, 0, {31'd0, v});
    endtask

    task automatic chk_now(input string n, input logic [31:0] act,
                           input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_wr();
        we0 = 1'b0; waddr0 = '0; wdata0 = '0;
        we1 = 1'b0; waddr1 = '0; wdata1 = '0;
        clear_req = 1'b0;
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
        raddr = {a1, a0};
    endtask

    function automatic logic [31:0] actual(input chk_t c);
        if (c.kind == 1)
            return {31'd0, (c.unit == 0) ? ready_a : ready_b};
        return (c.unit == 0) ? rdata_a[c.port*32 +: 32] : rdata_b[c.port*32 +: 32];
    endfunction

    // Monitor / scoreboard
    initial begin : monitor
        chk_t        mc;
        logic [31:0] act;
        do begin
            @(negedge clk);
            while (q.size() > 0) begin
                mc  = q.pop_front();
                act = actual(mc);
                checks++;
                if (act !== mc.exp) begin
                    errors++;
                    $display("FAIL %s unit%0d: got %h expected %h",
                             mc.name, mc.unit, act, mc.exp);
                end
            end
        end while (!done);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Stimulus
    initial begin : stim
        idle_wr();
        set_rd(5'd0, 5'd5);
        reset = 1'b1;
        cyc();
        chk_now("reset_ready_a", {31'd0, ready_a}, 32'h0);
        chk_now("reset_ready_b", {31'd0, ready_b}, 32'h0);
        chk_now("reset_rdata_a0", rdata_a[31:0], 32'h0);
        chk_now("reset_rdata_a1", rdata_a[63:32], 32'h0);
        chk_now("reset_rdata_b0", rdata_b[31:0], 32'h0);
        chk_now("reset_rdata_b1", rdata_b[63:32], 32'h0);
        reset = 1'b0;

        // Power-up sweep: unit 0 ready on edge 32, unit 1 on edge 24
        for (int e = 0; e <= 32; e++) begin
            rdy($sformatf("init_ready_e%0d", e), 0, e >= 32);
            rdy($sformatf("init_ready_e%0d", e), 1, e >= 24);
            rd($sformatf("init_rd0_e%0d", e), 0, 0, 32'h0);
            rd($sformatf("init_rd1_e%0d", e), 0, 1, 32'h0);
            rd($sformatf("init_rd0_e%0d", e), 1, 0, 32'h0);
            rd($sformatf("init_rd1_e%0d", e), 1, 1, 32'h0);
            cyc();
        end
        chk_now("wait_expired_ready_a", {31'd0, ready_a}, 32'h1);
        chk_now("wait_expired_ready_b", {31'd0, ready_b}, 32'h1);

        // Bypass vs registered write
        we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hDEADBEEF;
        set_rd(5'd5, 5'd6);
        rd("byp_same", 0, 0, 32'hDEADBEEF);
        rd("byp_same", 1, 0, 32'h0);
        cyc();
        idle_wr();
        rd("byp_after", 0, 0, 32'hDEADBEEF);
        rd("byp_after", 1, 0, 32'hDEADBEEF);
        cyc();

        // Address collision: port 1 wins
        we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h11;
        we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h22;
        set_rd(5'd7, 5'd7);
        rd("coll_byp0", 0, 0, 32'h22);
        rd("coll_byp1", 0, 1, 32'h22);
        rd("coll_nobyp", 1, 0, 32'h0);
        cyc();
        idle_wr();
        rd("coll_after0", 0, 0, 32'h22);
        rd("coll_after1", 0, 1, 32'h22);
        rd("coll_after0", 1, 0, 32'h22);
        rd("coll_after1", 1, 1, 32'h22);
        cyc();

        // Zero register ignores writes and reads 0
        we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'hFFFF;
        set_rd(5'd0, 5'd5);
        rd("zero_same", 0, 0, 32'h0);
        rd("zero_same", 1, 0, 32'h0);
        rd("keep5_same", 0, 1, 32'hDEADBEEF);
        cyc();
        idle_wr();
        rd("zero_after", 0, 0, 32'h0);
        rd("zero_after", 1, 0, 32'h0);
        rd("keep5_after", 1, 1, 32'hDEADBEEF);
        cyc();

        // Range boundary: 30 is out of range for unit 1, 23 is its last entry
        we0 = 1'b1; waddr0 = 5'd30; wdata0 = 32'hABCD;
        we1 = 1'b1; waddr1 = 5'd23; wdata1 = 32'h2323;
        set_rd(5'd30, 5'd23);
        rd("oor_same", 0, 0, 32'hABCD);
        rd("last_same", 0, 1, 32'h2323);
        rd("oor_same", 1, 0, 32'h0);
        rd("last_same", 1, 1, 32'h0);
        cyc();
        idle_wr();
        rd("oor_after", 0, 0, 32'hABCD);
        rd("last_after", 0, 1, 32'h2323);
        rd("oor_after", 1, 0, 32'h0);
        rd("last_after", 1, 1, 32'h2323);
        cyc();

        // Fill 1..31 with their own index
        for (int i = 1; i <= 31; i++) begin
            we0 = 1'b1; waddr0 = 5'(i); wdata0 = 32'(i);
            cyc();
        end
        idle_wr();
        set_rd(5'd3, 5'd31);
        rd("fill3", 0, 0, 32'd3);
        rd("fill31", 0, 1, 32'd31);
        rd("fill3", 1, 0, 32'd3);
        rd("fill31", 1, 1, 32'd0);
        cyc();
        set_rd(5'd23, 5'd24);
        rd("fill23", 0, 0, 32'd23);
        rd("fill24", 0, 1, 32'd24);
        rd("fill23", 1, 0, 32'd23);
        rd("fill24", 1, 1, 32'd0);
        cyc();

        // Clear request with a colliding write: write dropped, no bypass
        clear_req = 1'b1;
        we1 = 1'b1; waddr1 = 5'd3; wdata1 = 32'h99;
        set_rd(5'd3, 5'd31);
        rdy("clr_accept_ready", 0, 1'b1);
        rdy("clr_accept_ready", 1, 1'b1);
        rd("clr_accept_rd3", 0, 0, 32'd3);
        rd("clr_accept_rd31", 0, 1, 32'd31);
        rd("clr_accept_rd3", 1, 0, 32'd3);
        cyc();

        // Sweep; writes and clear requests during CLEAR are ignored
        for (int e = 0; e <= 32; e++) begin
            idle_wr();
            if (e < 20) begin
                clear_req = 1'b1;
                we0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'h55;
            end
            set_rd(5'd9, 5'd3);
            rdy($sformatf("clr_ready_e%0d", e), 0, e >= 32);
            rdy($sformatf("clr_ready_e%0d", e), 1, e >= 24);
            rd($sformatf("clr_rd9_e%0d", e), 0, 0, 32'h0);
            rd($sformatf("clr_rd3_e%0d", e), 0, 1, 32'h0);
            rd($sformatf("clr_rd9_e%0d", e), 1, 0, 32'h0);
            rd($sformatf("clr_rd3_e%0d", e), 1, 1, 32'h0);
            cyc();
        end
        idle_wr();

        // Every entry reads 0 after the sweep
        for (int i = 0; i < 32; i++) begin
            set_rd(5'(i), 5'(31 - i));
            rd($sformatf("swept_%0d", i), 0, 0, 32'h0);
            rd($sformatf("swept_%0d", 31 - i), 0, 1, 32'h0);
            rd($sformatf("swept_%0d", i), 1, 0, 32'h0);
            rd($sformatf("swept_%0d", 31 - i), 1, 1, 32'h0);
            cyc();
        end

        // Reset on sweep edge 10 restarts the sweep
        clear_req = 1'b1;
        rdy("rst_pre_ready", 0, 1'b1);
        rdy("rst_pre_ready", 1, 1'b1);
        cyc();
        clear_req = 1'b0;
        set_rd(5'd5, 5'd0);
        for (int s = 0; s < 10; s++) begin
            reset = (s == 9);
            rdy($sformatf("rst_sweep_e%0d", s), 0, 1'b0);
            rdy($sformatf("rst_sweep_e%0d", s), 1, 1'b0);
            cyc();
        end
        reset = 1'b0;
        for (int r = 0; r <= 32; r++) begin
            rdy($sformatf("rst_ready_e%0d", r), 0, r >= 32);
            rdy($sformatf("rst_ready_e%0d", r), 1, r >= 24);
            rd($sformatf("rst_rd5_e%0d", r), 0, 0, 32'h0);
            rd($sformatf("rst_rd5_e%0d", r), 1, 0, 32'h0);
            cyc();
        end
        chk_now("rst_wait_expired_ready_a", {31'd0, ready_a}, 32'h1);
        chk_now("rst_wait_expired_ready_b", {31'd0, ready_b}, 32'h1);

        done = 1'b1;
    end

endmodule : tb_reg_file_mp
`default_nettype wire

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-port successor to the core's single-write register file. Stores `NREGS` registers of `XLEN` bits, with `NRD` combinational read ports, two write ports and an optional hard-wired zero register. Optional same-cycle write-to-read bypass feeds the decode stage. A sequential clear engine zeroes the array one entry per cycle after reset or on request, so no full-array reset is needed.

## Interface
- `XLEN`, 32, data width.
- `NREGS`, 32, register count; 2..256, need not be a power of two.
- `NRD`, 2, read port count; 1..4.
- `ZERO_REG`, 1, 1 = entry 0 reads 0 and ignores writes.
- `BYPASS`, 1, 1 = same-cycle write data forwarded to matching reads.
- `AW` (localparam), `$clog2(NREGS)`, address width.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `clear_req` in 1: start a clear sweep; honoured only when `ready`=1.
- `ready` out 1: 1 = array valid; 0 during a clear sweep.
- `we0` in 1, `waddr0` in AW, `wdata0` in XLEN: write port 0.
- `we1` in 1, `waddr1` in AW, `wdata1` in XLEN: write port 1; wins on address collision.
- `raddr` in NRD*AW: read addresses, port k at bits [k*AW +: AW].
- `rdata` out NRD*XLEN: read data, port k at bits [k*XLEN +: XLEN].

## Operation
- FSM states: CLEAR, RUN.
- Reset: state CLEAR, sweep pointer `ptr` = 0, `ready` = 0. Array contents are not touched on the reset edge.
- CLEAR, each edge with `reset`=0:
  - write `mem[ptr]` <= 0, then `ptr` <= `ptr`+1.
  - At `ptr` = NREGS-1 the state goes to RUN.
  - Write ports and `clear_req` are ignored.
- RUN, `clear_req`=1: state goes to CLEAR with `ptr` = 0 on the next edge. Writes presented in that same cycle are dropped; clear takes priority.
- RUN writes:
  - Each enabled port writes its address on the edge.
  - If both ports target the same address, port 1's data is stored.
  - Writes to address 0 with `ZERO_REG`=1 are dropped.
  - Writes to address >= NREGS are dropped.
- Reads (combinational):
  - `rdata[k]` = `mem[raddr[k]]`.
  - 0 if `ready`=0.
  - 0 if the address is >= NREGS.
  - 0 if the address is 0 and `ZERO_REG`=1.
- Bypass (`BYPASS`=1, RUN, `clear_req`=0):
  - If `raddr[k]` matches an enabled, valid write address, `rdata[k]` returns that write data, port 1 before port 0.
  - The zero and out-of-range rules still take precedence.
- With `BYPASS`=0, reads return the pre-edge contents.

## Timing
- Reset values: `ready`=0, all `rdata`=0, state CLEAR, `ptr`=0.
- Sweep latency:
  - `ready` rises exactly NREGS edges after the first edge with `reset`=0.
  - The same NREGS-edge latency applies after the edge that accepts `clear_req`.
- `reset` asserted mid-sweep restarts `ptr` at 0 on the next edge.
- Write-to-read latency:
  - 0 cycles with bypass.
  - 1 edge without bypass.
- `ready` falls on the edge that accepts `clear_req`. The first cycle of CLEAR already reads 0.
- All outputs depend only on registered state plus the current read and write inputs. There is no extra pipeline stage.

## Structure
- Package `reg_file_pkg` holds:
  - `rf_state_t` enum {CLEAR, RUN}.
  - Function `rf_addr_ok(addr, nregs, zero_reg)` returning write/read legality, shared with the hazard unit.
- Sub-module `reg_file_clear_fsm`:
  - Contains the state register, `ptr` counter and `ready`.
  - Outputs `clr_en`/`clr_addr` to the array.
- Array, write arbitration and read/bypass muxing stay in the top module.

## Test plan
- Reset 1 cycle, then idle with `NREGS`=32: `ready`=0 for 32 edges, rises on edge 32; every `rdata`=0 throughout.
- RUN, `we0`=1, `waddr0`=5, `wdata0`=0xDEADBEEF, `raddr[0]`=5: with `BYPASS`=1, `rdata[0]`=0xDEADBEEF the same cycle; with `BYPASS`=0, it appears after the edge.
- Same cycle, `we0` addr 7 data 0x11 and `we1` addr 7 data 0x22: next cycle addr 7 reads 0x22; bypass in that cycle also shows 0x22.
- `we0`=1, `waddr0`=0, data 0xFFFF with `ZERO_REG`=1: `raddr` 0 reads 0 before and after the edge. With `NREGS`=24, a write to addr 30 is dropped and reads of 30 give 0.
- Fill regs 1..31 with their index, pulse `clear_req` together with `we1` addr 3 data 0x99: `ready` falls next edge; after 32 edges every register reads 0, including 3.
- Assert `reset` at sweep edge 10: `ready` stays 0 and rises 32 edges after `reset` deasserts.
